// File: rtl/adder_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module : adder_tree_pkg
// Brief  : Shared widths and FSM state type for the shared adder-tree arbiter.
// Rev    : 1.0
// ============================================================================
package adder_tree_pkg;

  localparam int A_W   = 4;
  localparam int C_W   = 8;
  localparam int SUM_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/adder_tree.sv
`default_nettype none
// ============================================================================
// Module : adder_tree
// Brief  : Two-level unsigned adder tree summing two 4-bit and two 8-bit terms.
// Rev    : 1.0
// ============================================================================
module adder_tree
  import adder_tree_pkg::*;
(
  input  logic [A_W-1:0]   i_a,
  input  logic [A_W-1:0]   i_b,
  input  logic [C_W-1:0]   i_c,
  input  logic [C_W-1:0]   i_d,
  output logic [SUM_W-1:0] o_sum3
);

  logic [SUM_W-1:0] w_sum_ab;
  logic [SUM_W-1:0] w_sum_cd;

  // Every term is zero-extended to the result width; 540 max fits in 10 bits.
  assign w_sum_ab = SUM_W'(i_a) + SUM_W'(i_b);
  assign w_sum_cd = SUM_W'(i_c) + SUM_W'(i_d);
  assign o_sum3   = w_sum_ab + w_sum_cd;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick: first set request after i_ptr.
// Rev    : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [ID_W-1:0] o_winner,
  output logic            o_any_req
);

  logic [ID_W-1:0] w_winner;
  logic [ID_W-1:0] w_cand;

  // Walk the ring backwards so the candidate closest to ptr+1 is written last.
  always_comb begin
    w_winner = '0;
    w_cand   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = ID_W'((int'(i_ptr) + k) % NREQ);
      if (i_req[w_cand]) begin
        w_winner = w_cand;
      end
    end
  end

  assign o_winner  = w_winner;
  assign o_any_req = |i_req;

endmodule
`default_nettype wire

// File: rtl/adder_tree_arbiter.sv
`default_nettype none
// ============================================================================
// Module : adder_tree_arbiter
// Brief  : Round-robin sharing of one adder tree among NREQ requesters.
// Rev    : 1.0
// ============================================================================
module adder_tree_arbiter
  import adder_tree_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*A_W-1:0] a_in,
  input  logic [NREQ*A_W-1:0] b_in,
  input  logic [NREQ*C_W-1:0] c_in,
  input  logic [NREQ*C_W-1:0] d_in,
  output logic [NREQ-1:0]     gnt,
  output logic                res_valid,
  output logic [ID_W-1:0]     res_id,
  output logic [SUM_W-1:0]    res_sum,
  input  logic                res_ready,
  output logic                busy
);

  state_t           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic             r_valid;
  logic [ID_W-1:0]  r_id;
  logic [SUM_W-1:0] r_sum;
  logic [ID_W-1:0]  r_ptr;
  logic [A_W-1:0]   r_op_a;
  logic [A_W-1:0]   r_op_b;
  logic [C_W-1:0]   r_op_c;
  logic [C_W-1:0]   r_op_d;

  logic [ID_W-1:0]  w_winner;
  logic             w_any_req;
  logic [SUM_W-1:0] w_sum3;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  adder_tree u_adder_tree (
    .i_a    (r_op_a),
    .i_b    (r_op_b),
    .i_c    (r_op_c),
    .i_d    (r_op_d),
    .o_sum3 (w_sum3)
  );

  // ptr resets to the last index so requester 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_sum   <= '0;
      r_ptr   <= ID_W'(NREQ - 1);
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_op_c  <= '0;
      r_op_d  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_op_a  <= a_in[w_winner*A_W +: A_W];
            r_op_b  <= b_in[w_winner*A_W +: A_W];
            r_op_c  <= c_in[w_winner*C_W +: C_W];
            r_op_d  <= d_in[w_winner*C_W +: C_W];
            r_gnt   <= NREQ'(1) << w_winner;
            r_id    <= w_winner;
            r_ptr   <= w_winner;
            r_state <= CALC;
          end else begin
            r_gnt   <= '0;
          end
        end
        CALC: begin
          r_sum   <= w_sum3;
          r_valid <= 1'b1;
          r_gnt   <= '0;
          r_state <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign res_valid = r_valid;
  assign res_id    = r_id;
  assign res_sum   = r_sum;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_adder_tree_arbiter
// Brief  : Directed plus randomized bench with a transaction-level reference.
// Rev    : 1.0
// ============================================================================
module tb_adder_tree_arbiter;
  import adder_tree_pkg::*;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [NREQ*A_W-1:0] a_in;
  logic [NREQ*A_W-1:0] b_in;
  logic [NREQ*C_W-1:0] c_in;
  logic [NREQ*C_W-1:0] d_in;
  logic [NREQ-1:0]     gnt;
  logic                res_valid;
  logic [ID_W-1:0]     res_id;
  logic [SUM_W-1:0]    res_sum;
  logic                res_ready;
  logic                busy;

  always #5 clk = ~clk;

  adder_tree_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .d_in      (d_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_ready (res_ready),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: a transaction is granted, summed one edge later, then held
  // until the consumer accepts it; ring search resumes after the last winner.
  int m_last;
  int m_step;
  int m_id;
  int m_pend_sum;
  int m_res_sum;
  bit m_valid;
  int g_order[$];

  function automatic int req_sum(int i);
    return int'(a_in[i*A_W +: A_W]) + int'(b_in[i*A_W +: A_W]) +
           int'(c_in[i*C_W +: C_W]) + int'(d_in[i*C_W +: C_W]);
  endfunction

  task automatic model_reset();
    m_last     = NREQ - 1;
    m_step     = 0;
    m_id       = 0;
    m_pend_sum = 0;
    m_res_sum  = 0;
    m_valid    = 1'b0;
  endtask

  task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
    a_in[i*A_W +: A_W] = A_W'(a);
    b_in[i*A_W +: A_W] = A_W'(b);
    c_in[i*C_W +: C_W] = C_W'(c);
    d_in[i*C_W +: C_W] = C_W'(d);
  endtask

  task automatic tick();
    int exp_gnt;
    bit found;
    exp_gnt = 0;
    found   = 1'b0;
    if (m_step == 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_last + k) % NREQ;
        if (!found && req[idx]) begin
          found      = 1'b1;
          exp_gnt    = 1 << idx;
          m_id       = idx;
          m_last     = idx;
          m_pend_sum = req_sum(idx);
          m_step     = 1;
        end
      end
    end else if (m_step == 1) begin
      m_res_sum = m_pend_sum;
      m_valid   = 1'b1;
      m_step    = 2;
    end else if (res_ready) begin
      m_valid = 1'b0;
      m_step  = 0;
    end
    @(posedge clk);
    #1;
    check_val("gnt", 32'(gnt), 32'(exp_gnt));
    check_val("res_valid", 32'(res_valid), 32'(m_valid));
    check_val("busy", 32'(busy), 32'(m_step != 0));
    check_val("res_id", 32'(res_id), 32'(m_id));
    check_val("res_sum", 32'(res_sum), 32'(m_res_sum));
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) g_order.push_back(i);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_gnt"}, 32'(gnt), 0);
    check_val({tag, "_valid"}, 32'(res_valid), 0);
    check_val({tag, "_sum"}, 32'(res_sum), 0);
    check_val({tag, "_id"}, 32'(res_id), 0);
    check_val({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_order(input string tag, input int exp_ids[4]);
    check_val({tag, "_count"}, 32'(g_order.size()), 4);
    for (int k = 0; k < 4 && k < g_order.size(); k++) begin
      check_val($sformatf("%s_%0d", tag, k), 32'(g_order[k]), 32'(exp_ids[k]));
    end
  endtask

  task automatic drive_random();
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && gnt[i]) begin
        req[i] = 1'b0;
      end else if (!req[i]) begin
        if ($urandom_range(0, 99) < 30) begin
          req[i] = 1'b1;
          if ($urandom_range(0, 9) == 0) set_ops(i, 15, 15, 255, 255);
          else set_ops(i, $urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 255), $urandom_range(0, 255));
        end
      end else if ($urandom_range(0, 99) < 3) begin
        req[i] = 1'b0;
      end
    end
    res_ready = ($urandom_range(0, 99) < 60);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ord_all[4];
    int ord_fair[4];
    ord_all  = '{0, 1, 2, 3};
    ord_fair = '{0, 2, 0, 2};
    a_in = '0; b_in = '0; c_in = '0; d_in = '0;
    model_reset();
    do_reset();

    // Single request
    set_ops(0, 0, 3, 1, 255);
    req = 4'b0001; res_ready = 1'b1;
    tick();
    check_val("single_gnt", 32'(gnt), 1);
    req = '0;
    tick();
    check_val("single_sum", 32'(res_sum), 259);
    check_val("single_id", 32'(res_id), 0);
    check_val("single_valid", 32'(res_valid), 1);
    tick();
    check_val("single_busy", 32'(busy), 0);

    // All four requesting continuously
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, i, i + 1, 10 * i, 200 - i);
    req = 4'b1111; res_ready = 1'b1;
    g_order.delete();
    repeat (12) tick();
    check_order("all", ord_all);

    // Fairness between requesters 0 and 2
    do_reset();
    req = 4'b0101; res_ready = 1'b1;
    g_order.delete();
    repeat (12) tick();
    check_order("fair", ord_fair);

    // Backpressure while requester 3 waits
    do_reset();
    set_ops(1, 15, 15, 109, 37);
    set_ops(3, 1, 2, 3, 4);
    req = 4'b0010; res_ready = 1'b0;
    tick();
    req = 4'b1000;
    repeat (5) begin
      tick();
      check_val("bp_sum", 32'(res_sum), 176);
      check_val("bp_id", 32'(res_id), 1);
      check_val("bp_valid", 32'(res_valid), 1);
      check_val("bp_gnt", 32'(gnt), 0);
    end
    res_ready = 1'b1;
    tick();
    tick();
    check_val("bp_next_gnt", 32'(gnt), 8);
    req = '0;
    repeat (3) tick();

    // Largest operands
    set_ops(0, 15, 15, 255, 255);
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    check_val("max_sum", 32'(res_sum), 540);
    tick();

    // Reset while the transaction sits in CALC
    do_reset();
    req = 4'b1111; res_ready = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_calc");
    @(posedge clk);
    #1;
    check_zero_outputs("rst_calc_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    check_val("rst_calc_regrant", 32'(gnt), 1);

    // Randomized traffic
    do_reset();
    repeat (1500) begin
      tick();
      drive_random();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_tree_arbiter.md
# adder_tree_arbiter

Shares one four-operand adder tree among NREQ requesters. Each requester presents two 4-bit and two 8-bit unsigned operands. A round-robin arbiter picks one request at a time, registers its operands, and returns the registered 10-bit sum with the winner's ID over a valid/ready result port. It sits between the requesting datapaths and the single adder_tree instance, so the adder is never duplicated.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- ID_W, $clog2(NREQ), result ID width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request; hold high with stable operands until own gnt bit seen
- a_in  in  NREQ*4  operand a, requester i at [4i+3:4i]
- b_in  in  NREQ*4  operand b, same packing
- c_in  in  NREQ*8  operand c, requester i at [8i+7:8i]
- d_in  in  NREQ*8  operand d, same packing
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester were captured
- res_valid  out  1  result available
- res_id  out  ID_W  requester index owning res_sum
- res_sum  out  10  a+b+c+d
- res_ready  in  1  consumer accepts result
- busy  out  1  state != IDLE

## Operation
- FSM states IDLE, CALC, HOLD.
- IDLE, edge with req != 0:
  - winner = first set req bit searching ptr+1, ptr+2, … wrapping modulo NREQ
  - capture the winner's four operands into op registers
  - gnt <= onehot(winner), res_id <= winner, ptr <= winner
  - state <= CALC
- IDLE, req == 0: stay; gnt <= 0.
- CALC, next edge:
  - res_sum <= a+b+c+d of the captured operands (all zero-extended to 10 bits)
  - res_valid <= 1, gnt <= 0
  - state <= HOLD
- HOLD:
  - res_valid, res_sum and res_id are held stable.
  - On an edge with res_ready=1: res_valid <= 0, state <= IDLE.
- req is ignored in CALC and HOLD. Pending requesters keep req high and wait.
- Arithmetic: the maximum sum is 15+15+255+255=540, which is below 1024, so there is no overflow and no saturation.
- A requester that drops req before being granted is simply skipped. It is never granted later from stale state.
- Reset values (async on rst_n=0): state=IDLE, gnt=0, res_valid=0, res_sum=0, res_id=0, ptr=NREQ-1 (requester 0 has first priority), op registers=0.
- Reset mid-transaction discards the in-flight operation. No result is produced, and no gnt is reissued for it.

## Timing
- Edge E0 (IDLE, req seen): gnt visible during cycle E0..E1.
- Edge E1: res_valid=1 visible from E1.
- Request-to-result latency is 2 edges.
- With res_ready held high, res_valid is high for exactly one cycle and the handshake completes at E2. The state returns to IDLE at E2, and the next grant occurs at E3.
- Peak throughput: one result per 3 cycles.
- gnt is never asserted in the same cycle as res_valid for a different transaction. Exception: none, because the grant and the result are separated by CALC.
- busy is combinational from the state register. It is high from E0 until the handshake edge.

## Structure
- adder_tree_pkg holds:
  - width constants A_W=4, C_W=8, SUM_W=10
  - the state typedef (IDLE, CALC, HOLD)
- Sub-module rr_arbiter (parameter NREQ): inputs req and ptr, output winner index and any_req. It is purely combinational.
- The existing adder_tree is instantiated once on the op registers. Its sum3 output is registered into res_sum.

## Test plan
- Single request: req[0]=1 with a=0, b=3, c=1, d=255, res_ready=1 → gnt=0001 for one cycle; res_valid at E1 with res_sum=259, res_id=0; busy low after E2.
- Simultaneous requests: req=1111 all held, res_ready=1 → service order 0,1,2,3, each on a 3-cycle spacing, with one gnt bit per grant.
- Fairness: req[0] and req[2] held continuously → grants alternate 0,2,0,2; requester 1 and requester 3 are never granted.
- Backpressure: req[1] with a=15, b=15, c=109, d=37 and res_ready=0 for 5 cycles → res_sum=176 and res_id=1 stay stable; res_valid stays high; no new gnt while req[3] is pending; req[3] is granted the cycle after res_ready rises.
- Max operands: a=15, b=15, c=255, d=255 → res_sum=540.
- Reset in CALC: assert rst_n=0 one cycle after gnt → all outputs zero immediately, no res_valid; after release, req=1111 is granted to requester 0 first.
